// File: rtl/kernel_launch_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_launch_controller_pkg
//  Description : Shared types and constants for the kernel launch controller.
//                Holds the launch descriptor layout, MMIO register offsets,
//                STATUS bit positions, the controller state enum and a
//                helper that assembles the STATUS read word.
//  Revision    : 1.0 - initial release
// ============================================================================
package kernel_launch_controller_pkg;

  // Field order matches the GPU's kernel_config_t (base_instr in the MSBs).
  typedef struct packed {
    logic [31:0] base_instr;
    logic [31:0] base_data;
    logic [31:0] num_blocks;
    logic [31:0] warps_per_block;
  } launch_desc_t;

  // MMIO register byte offsets
  localparam logic [7:0] c_addr_base_instr  = 8'h00;
  localparam logic [7:0] c_addr_base_data   = 8'h04;
  localparam logic [7:0] c_addr_num_blocks  = 8'h08;
  localparam logic [7:0] c_addr_warps       = 8'h0C;
  localparam logic [7:0] c_addr_control     = 8'h10;
  localparam logic [7:0] c_addr_status      = 8'h14;
  localparam logic [7:0] c_addr_last_cycles = 8'h18;

  // STATUS bit positions
  localparam int c_st_done        = 0;
  localparam int c_st_err_zero    = 1;
  localparam int c_st_err_ovf     = 2;
  localparam int c_st_err_timeout = 3;
  localparam int c_st_busy        = 4;
  localparam int c_st_qcount_lsb  = 8;
  localparam int c_st_ccount_lsb  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIG   = 2'd1,
    RUN      = 2'd2,
    COMPLETE = 2'd3
  } launch_state_t;

  // Assemble the STATUS read word from its component fields.
  function automatic logic [31:0] pack_status(
    input logic [3:0]  flags,
    input logic        busy,
    input logic [3:0]  qcount,
    input logic [15:0] ccount
  );
    logic [31:0] w_word;
    w_word                          = '0;
    w_word[c_st_done]               = flags[0];
    w_word[c_st_err_zero]           = flags[1];
    w_word[c_st_err_ovf]            = flags[2];
    w_word[c_st_err_timeout]        = flags[3];
    w_word[c_st_busy]               = busy;
    w_word[c_st_qcount_lsb +: 4]    = qcount;
    w_word[c_st_ccount_lsb +: 16]   = ccount;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_launch_controller_launch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_launch_controller_launch_fifo
//  Description : Synchronous first-word-fall-through FIFO of launch
//                descriptors. The head entry is visible on pop_data whenever
//                empty is low; pop consumes it at the clock edge.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                push, push_data - write an entry (ignored when full)
//                pop, pop_data   - consume head entry (ignored when empty)
//                full, empty     - occupancy flags
//                count           - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_launch_controller_launch_fifo
  import kernel_launch_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  launch_desc_t             push_data,
  input  logic                     pop,
  output launch_desc_t             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  launch_desc_t      r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == (c_aw + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/kernel_launch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_launch_controller
//  Description : Host-facing launch front end for the GPU. Host MMIO writes
//                fill staging registers; a CONTROL write snapshots them into
//                a launch queue. The sequencer pops one descriptor at a time,
//                releases the GPU from reset, raises execution_start and
//                waits for execution_done (or a timeout). The GPU is put back
//                into reset between kernels because its start latch only
//                clears on reset.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                host_wr_*             - register write port (always accepted)
//                host_rd_* / resp      - register read port, 1-cycle response
//                irq                   - level interrupt (DONE or any error)
//                gpu_reset             - reset to the GPU
//                base_instr..warps_per_block - kernel config to the GPU
//                execution_start/done  - GPU run handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_launch_controller
  import kernel_launch_controller_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int CONFIG_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_wr_valid,
  input  logic [7:0]  host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic        host_rd_valid,
  input  logic [7:0]  host_rd_addr,
  output logic        host_rd_resp_valid,
  output logic [31:0] host_rd_data,
  output logic        irq,
  output logic        gpu_reset,
  output logic [31:0] base_instr,
  output logic [31:0] base_data,
  output logic [31:0] num_blocks,
  output logic [31:0] warps_per_block,
  output logic        execution_start,
  input  logic        execution_done
);

  localparam int          c_cnt_w       = $clog2(QUEUE_DEPTH) + 1;
  localparam int          c_cfg_w       = $clog2(CONFIG_CYCLES + 1);
  localparam logic        c_timeout_en  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_timeout_val = 32'(TIMEOUT_CYCLES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  launch_desc_t        r_stage;
  launch_desc_t        r_cfg;
  launch_state_t       r_state;
  logic [c_cfg_w-1:0]  r_cfg_cnt;
  logic [31:0]         r_cycle_cnt;
  logic [31:0]         r_last_cycles;
  logic                r_timed_out;
  logic                r_gpu_reset;
  logic                r_exec_start;
  logic [3:0]          r_flags;       // {timeout, ovf, zero, done}
  logic [15:0]         r_ccount;
  logic                r_irq;
  logic                r_rd_valid;
  logic [31:0]         r_rd_data;

  launch_desc_t        w_fifo_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_cnt_w-1:0]  w_fifo_count;

  logic                w_wr_control;
  logic                w_wr_status;
  logic                w_stage_zero;
  logic                w_push;
  logic                w_pop;
  logic [3:0]          w_flags_set;
  logic [3:0]          w_flags_clr;
  logic [3:0]          w_flags_next;
  logic [31:0]         w_rd_mux;

  // --------------------------------------------------------------------------
  // Enqueue decode. The zero check has priority over the full check, and
  // fullness is judged before any same-cycle pop frees a slot.
  // --------------------------------------------------------------------------
  assign w_wr_control = host_wr_valid && (host_wr_addr == c_addr_control) && host_wr_data[0];
  assign w_wr_status  = host_wr_valid && (host_wr_addr == c_addr_status);
  assign w_stage_zero = (r_stage.num_blocks == '0) || (r_stage.warps_per_block == '0);
  assign w_push       = w_wr_control && !w_stage_zero && !w_fifo_full;
  assign w_pop        = (r_state == IDLE) && !w_fifo_empty;

  kernel_launch_controller_launch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_launch_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (r_stage),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // --------------------------------------------------------------------------
  // Staging registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
    end else if (host_wr_valid) begin
      case (host_wr_addr)
        c_addr_base_instr: r_stage.base_instr      <= host_wr_data;
        c_addr_base_data:  r_stage.base_data       <= host_wr_data;
        c_addr_num_blocks: r_stage.num_blocks      <= host_wr_data;
        c_addr_warps:      r_stage.warps_per_block <= host_wr_data;
        default:           r_stage                 <= r_stage;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Launch sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_gpu_reset   <= 1'b1;
      r_exec_start  <= 1'b0;
      r_cfg         <= '0;
      r_cfg_cnt     <= '0;
      r_cycle_cnt   <= '0;
      r_last_cycles <= '0;
      r_timed_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gpu_reset  <= 1'b1;
          r_exec_start <= 1'b0;
          if (!w_fifo_empty) begin
            r_cfg       <= w_fifo_head;
            r_cfg_cnt   <= '0;
            r_gpu_reset <= 1'b0;
            r_state     <= CONFIG;
          end
        end
        CONFIG: begin
          if (r_cfg_cnt == c_cfg_w'(CONFIG_CYCLES - 1)) begin
            r_exec_start <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_cfg_cnt <= r_cfg_cnt + c_cfg_w'(1);
          end
        end
        RUN: begin
          // The counter holds the number of RUN cycles that elapsed without
          // execution_done; done takes priority over a coincident timeout.
          if (execution_done) begin
            r_timed_out  <= 1'b0;
            r_gpu_reset  <= 1'b1;
            r_exec_start <= 1'b0;
            r_state      <= COMPLETE;
          end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (c_timeout_en && (r_cycle_cnt + 32'd1 == c_timeout_val)) begin
              r_timed_out  <= 1'b1;
              r_gpu_reset  <= 1'b1;
              r_exec_start <= 1'b0;
              r_state      <= COMPLETE;
            end
          end
        end
        COMPLETE: begin
          r_last_cycles <= r_cycle_cnt;
          r_cycle_cnt   <= '0;
          r_state       <= IDLE;
        end
        default: begin
          r_gpu_reset  <= 1'b1;
          r_exec_start <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // STATUS flags: set events win over a same-cycle write-1-to-clear.
  // irq is computed from the next flag value so it tracks STATUS exactly.
  // --------------------------------------------------------------------------
  always_comb begin
    w_flags_set    = '0;
    w_flags_set[0] = (r_state == COMPLETE) && !r_timed_out;
    w_flags_set[1] = w_wr_control && w_stage_zero;
    w_flags_set[2] = w_wr_control && !w_stage_zero && w_fifo_full;
    w_flags_set[3] = (r_state == COMPLETE) && r_timed_out;
    w_flags_clr    = w_wr_status ? host_wr_data[3:0] : 4'b0000;
    w_flags_next   = (r_flags & ~w_flags_clr) | w_flags_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags  <= '0;
      r_ccount <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_flags <= w_flags_next;
      r_irq   <= |w_flags_next;
      if (w_flags_set[0]) begin
        r_ccount <= r_ccount + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register read: captures state at the request cycle, so a same-cycle
  // write is not yet visible.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = '0;
    case (host_rd_addr)
      c_addr_base_instr:  w_rd_mux = r_stage.base_instr;
      c_addr_base_data:   w_rd_mux = r_stage.base_data;
      c_addr_num_blocks:  w_rd_mux = r_stage.num_blocks;
      c_addr_warps:       w_rd_mux = r_stage.warps_per_block;
      c_addr_status:      w_rd_mux = pack_status(r_flags, (r_state != IDLE),
                                                 4'(w_fifo_count), r_ccount);
      c_addr_last_cycles: w_rd_mux = r_last_cycles;
      default:            w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= host_rd_valid;
      r_rd_data  <= host_rd_valid ? w_rd_mux : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign host_rd_resp_valid = r_rd_valid;
  assign host_rd_data       = r_rd_data;
  assign irq                = r_irq;
  assign gpu_reset          = r_gpu_reset;
  assign execution_start    = r_exec_start;
  assign base_instr         = r_cfg.base_instr;
  assign base_data          = r_cfg.base_data;
  assign num_blocks         = r_cfg.num_blocks;
  assign warps_per_block    = r_cfg.warps_per_block;

endmodule
`default_nettype wire

// File: tb/tb_kernel_launch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kernel_launch_controller
//  Description : Self-checking bench for kernel_launch_controller. Register
//                reads push their expected value into a scoreboard queue; a
//                monitor pops and compares on every read response. GPU-side
//                outputs are checked directly at known cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_launch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_wr_valid = 1'b0;
  logic [7:0]  host_wr_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic        host_rd_valid = 1'b0;
  logic [7:0]  host_rd_addr = '0;
  logic        host_rd_resp_valid;
  logic [31:0] host_rd_data;
  logic        irq;
  logic        gpu_reset;
  logic [31:0] base_instr;
  logic [31:0] base_data;
  logic [31:0] num_blocks;
  logic [31:0] warps_per_block;
  logic        execution_start;
  logic        execution_done = 1'b0;

  always #5 clk = ~clk;

  kernel_launch_controller #(
    .QUEUE_DEPTH    (4),
    .CONFIG_CYCLES  (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .host_wr_valid      (host_wr_valid),
    .host_wr_addr       (host_wr_addr),
    .host_wr_data       (host_wr_data),
    .host_rd_valid      (host_rd_valid),
    .host_rd_addr       (host_rd_addr),
    .host_rd_resp_valid (host_rd_resp_valid),
    .host_rd_data       (host_rd_data),
    .irq                (irq),
    .gpu_reset          (gpu_reset),
    .base_instr         (base_instr),
    .base_data          (base_data),
    .num_blocks         (num_blocks),
    .warps_per_block    (warps_per_block),
    .execution_start    (execution_start),
    .execution_done     (execution_done)
  );

  localparam logic [7:0] A_BI = 8'h00, A_BD = 8'h04, A_NB = 8'h08, A_WP = 8'h0C;
  localparam logic [7:0] A_CTRL = 8'h10, A_STAT = 8'h14, A_LAST = 8'h18;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  rd_exp_t     sb[$];
  rd_exp_t     mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [127:0] prev_cfg;
  logic         prev_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read response is matched to the oldest request.
  always @(negedge clk) begin
    if (host_rd_resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_resp: got data 0x%0h, expected no response", host_rd_data);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, host_rd_data, mon_e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    tick();
    host_wr_valid = 1'b0;
  endtask

  task automatic expect_rd(input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    expect_rd(exp, name);
    host_rd_valid = 1'b1;
    host_rd_addr  = a;
    tick();
    host_rd_valid = 1'b0;
  endtask

  task automatic stage(input logic [31:0] bi, input logic [31:0] bd,
                       input logic [31:0] nb, input logic [31:0] wp);
    wr(A_BI, bi);
    wr(A_BD, bd);
    wr(A_NB, nb);
    wr(A_WP, wp);
  endtask

  // Waits (bounded) for execution_start, counting gpu_reset-high cycles and
  // checking that config only changes right after a gpu_reset-high cycle.
  task automatic wait_start(input string name, output int rst_hi);
    int n;
    rst_hi   = 0;
    n        = 0;
    prev_cfg = {base_instr, base_data, num_blocks, warps_per_block};
    prev_rst = gpu_reset;
    while (execution_start !== 1'b1 && n < 40) begin
      if (gpu_reset) rst_hi++;
      tick();
      n++;
      if ({base_instr, base_data, num_blocks, warps_per_block} != prev_cfg)
        check({name, "_cfg_chg_in_rst"}, 32'(prev_rst), 32'd1);
      prev_cfg = {base_instr, base_data, num_blocks, warps_per_block};
      prev_rst = gpu_reset;
    end
    check({name, "_start_seen"}, 32'(n < 40), 32'd1);
  endtask

  initial begin
    int rst_hi;

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset = 1'b0;
    check("rst_gpu_reset", 32'(gpu_reset), 32'd1);
    check("rst_exec_start", 32'(execution_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rd_resp_valid", 32'(host_rd_resp_valid), 32'd0);
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_LAST, 32'h0, "rst_last_cycles");

    // ---------------- single launch, latency, LAST_CYCLES ----------------
    stage(32'h0, 32'h100, 32'd4, 32'd2);
    rd(A_BD, 32'h100, "stage_base_data");
    wr(A_CTRL, 32'h1);                       // cycle t
    rd(A_STAT, 32'h0000_0100, "t1_qcount1"); // issued t+1
    check("t2_gpu_reset", 32'(gpu_reset), 32'd0);
    check("t2_exec_start", 32'(execution_start), 32'd0);
    check("t2_num_blocks", num_blocks, 32'd4);
    check("t2_warps", warps_per_block, 32'd2);
    check("t2_base_data", base_data, 32'h100);
    tick();
    check("t3_gpu_reset", 32'(gpu_reset), 32'd0);
    check("t3_exec_start", 32'(execution_start), 32'd0);
    tick();
    check("t4_exec_start", 32'(execution_start), 32'd1);
    repeat (10) tick();
    execution_done = 1'b1;
    tick();
    execution_done = 1'b0;
    check("complete_gpu_reset", 32'(gpu_reset), 32'd1);
    check("complete_exec_start", 32'(execution_start), 32'd0);
    tick();
    check("done_irq", 32'(irq), 32'd1);
    rd(A_STAT, 32'h0001_0001, "done_status");
    rd(A_LAST, 32'd10, "last_cycles_10");
    wr(A_STAT, 32'h1);
    check("w1c_irq", 32'(irq), 32'd0);
    rd(A_STAT, 32'h0001_0000, "w1c_status");

    // ---------------- overflow, then timeout ----------------
    stage(32'h200, 32'h300, 32'd1, 32'd1);
    repeat (5) wr(A_CTRL, 32'h1);            // c0..c4
    wr(A_CTRL, 32'h1);                       // c5: queue full
    rd(A_STAT, 32'h0001_0414, "ovf_status"); // c6: count 4, busy, OVF
    check("ovf_irq", 32'(irq), 32'd1);
    wr(A_STAT, 32'h4);                       // c7
    check("c8_exec_start", 32'(execution_start), 32'd1);
    check("ovf_clr_irq", 32'(irq), 32'd0);
    repeat (15) tick();                      // c23: 20th RUN cycle
    check("c23_exec_start", 32'(execution_start), 32'd1);
    tick();                                  // c24: COMPLETE
    check("tmo_gpu_reset", 32'(gpu_reset), 32'd1);
    check("tmo_exec_start", 32'(execution_start), 32'd0);
    tick();                                  // c25: IDLE
    rd(A_STAT, 32'h0001_0408, "tmo_status");
    check("tmo_next_launch", 32'(gpu_reset), 32'd0);
    check("tmo_irq", 32'(irq), 32'd1);
    rd(A_LAST, 32'd20, "last_cycles_20");
    tick();                                  // c28: RUN
    check("c28_exec_start", 32'(execution_start), 32'd1);

    // ---------------- reset mid-run ----------------
    reset = 1'b1;
    tick();
    check("midrst_gpu_reset", 32'(gpu_reset), 32'd1);
    check("midrst_exec_start", 32'(execution_start), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();
    rd(A_STAT, 32'h0, "midrst_status");

    // ---------------- read/write same cycle, zero config, unmapped ----------------
    expect_rd(32'h0, "rw_same_cycle");
    host_wr_valid = 1'b1; host_wr_addr = A_BI; host_wr_data = 32'hABCD;
    host_rd_valid = 1'b1; host_rd_addr = A_BI;
    tick();
    host_wr_valid = 1'b0; host_rd_valid = 1'b0;
    rd(A_BI, 32'hABCD, "rw_after_write");
    wr(A_WP, 32'd2);
    wr(A_NB, 32'd0);
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 32'h0000_0002, "zero_nb_status");
    check("zero_gpu_reset", 32'(gpu_reset), 32'd1);
    wr(A_STAT, 32'h2);
    wr(A_NB, 32'd3);
    wr(A_WP, 32'd0);
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 32'h0000_0002, "zero_wp_status");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "zero_cleared");
    rd(8'h40, 32'h0, "unmapped_read");
    rd(A_CTRL, 32'h0, "control_read");

    // ---------------- back-to-back kernels ----------------
    stage(32'h10, 32'h20, 32'd3, 32'd1);
    wr(A_CTRL, 32'h1);
    stage(32'h30, 32'h40, 32'd5, 32'd6);   // must not alter queued K1
    wr(A_CTRL, 32'h1);
    wait_start("k1", rst_hi);
    check("k1_base_instr", base_instr, 32'h10);
    check("k1_base_data", base_data, 32'h20);
    check("k1_num_blocks", num_blocks, 32'd3);
    check("k1_warps", warps_per_block, 32'd1);
    repeat (3) tick();
    execution_done = 1'b1;
    tick();
    execution_done = 1'b0;
    wait_start("k2", rst_hi);
    check("k2_rst_gap_ge2", 32'(rst_hi >= 2), 32'd1);
    check("k2_base_instr", base_instr, 32'h30);
    check("k2_base_data", base_data, 32'h40);
    check("k2_num_blocks", num_blocks, 32'd5);
    check("k2_warps", warps_per_block, 32'd6);
    execution_done = 1'b1;
    tick();
    execution_done = 1'b0;
    tick();
    rd(A_STAT, 32'h0002_0001, "b2b_status");

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kernel_launch_controller.md
Name: kernel_launch_controller

Overview:
- Host-facing launch front end placed directly upstream of the GPU top level.
- Accepts MMIO register writes that describe a kernel and queues launch descriptors in a FIFO.
- Drives the GPU's configuration inputs, execution_start and a GPU-side reset, then waits for execution_done.
- Sequences back-to-back kernels by holding the GPU in reset between launches, because the GPU's start latch only clears on reset. Also reports status, errors and a completion interrupt.

Parameters:
- QUEUE_DEPTH, 4, number of queued launch descriptors (power of 2, at least 2).
- CONFIG_CYCLES, 2, cycles that config is driven stable with gpu_reset low before execution_start rises (minimum 2).
- TIMEOUT_CYCLES, 0, RUN cycle limit before forced abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- host_wr_valid  in  1  register write strobe; always accepted, no ready signal
- host_wr_addr  in  8  byte offset of the register
- host_wr_data  in  32  write data
- host_rd_valid  in  1  register read request
- host_rd_addr  in  8  byte offset of the register
- host_rd_resp_valid  out  1  read response, 1 cycle after host_rd_valid
- host_rd_data  out  32  read data
- irq  out  1  level interrupt: DONE or any error bit set
- gpu_reset  out  1  drives the GPU's reset
- base_instr  out  32  to GPU
- base_data  out  32  to GPU
- num_blocks  out  32  to GPU
- warps_per_block  out  32  to GPU
- execution_start  out  1  to GPU
- execution_done  in  1  from GPU

Behaviour:
- Register map:
  - 0x00 BASE_INSTR (RW staging), 0x04 BASE_DATA, 0x08 NUM_BLOCKS, 0x0C WARPS_PER_BLOCK.
  - 0x10 CONTROL: writing bit0=1 enqueues a snapshot of the four staging registers. Reads return 0.
  - 0x14 STATUS (read / W1C):
    - bit0 DONE (W1C); bit1 ERR_ZERO (W1C); bit2 ERR_OVF (W1C); bit3 ERR_TIMEOUT (W1C).
    - bit4 BUSY (read-only, state != IDLE).
    - bits[11:8] queue count (read-only).
    - bits[31:16] completed-kernel count (read-only, wraps at 16 bits).
  - 0x18 LAST_CYCLES (RO): RUN-state cycle count of the last finished kernel.
  - Unmapped offsets: writes are ignored, reads return 0.
- Reset values:
  - gpu_reset=1, execution_start=0.
  - All config outputs, staging registers, STATUS, LAST_CYCLES and the queue = 0.
  - irq=0, host_rd_resp_valid=0.
  - FSM in IDLE.
- All outputs are registered.
- Enqueue rules, in priority order:
  - NUM_BLOCKS==0 or WARPS_PER_BLOCK==0 → rejected, ERR_ZERO set.
  - Else queue full → rejected, ERR_OVF set.
  - Else entry appears in the queue count on the next cycle.
  - Staging writes never alter entries already queued.
  - A staging write and a CONTROL write in the same cycle cannot happen (single write port). A CONTROL enqueue uses staging values as of that cycle.
- FSM states:
  - IDLE: gpu_reset=1, execution_start=0. If the queue is non-empty, pop the head into the config outputs and go to CONFIG.
  - CONFIG: gpu_reset=0, config outputs held, execution_start=0, for CONFIG_CYCLES cycles, then RUN.
  - RUN: execution_start=1, config held, cycle counter increments each cycle.
    - On execution_done=1 go to COMPLETE.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to COMPLETE with ERR_TIMEOUT set and DONE not set.
  - COMPLETE (1 cycle): gpu_reset=1, execution_start=0, LAST_CYCLES←counter, counter cleared. On a normal finish, set DONE and increment the completed count. Then go to IDLE.
- Back-to-back kernels therefore pass through at least 1 cycle of COMPLETE and 1 cycle of IDLE with gpu_reset=1.
- Pop and enqueue in the same cycle: both happen and the count is unchanged. A full queue with a simultaneous pop still rejects (full is evaluated before the pop).
- W1C on STATUS in the same cycle as a set event: the set wins.
- Launch latency: CONTROL write at cycle t into an empty, idle controller gives:
  - count=1 at t+1;
  - CONFIG (gpu_reset=0) at t+2..t+3;
  - execution_start=1 from t+4.
- A reset mid-run returns everything to reset values immediately, with gpu_reset=1 on the next cycle. Queued launches are lost.
- Read data is captured from register state at the request cycle. A read and a write in the same cycle return the pre-write value.

Decomposition:
- Shared package (common.svh):
  - launch_desc_t, a 128-bit struct with the four fields, same ordering as the GPU's kernel_config_t;
  - the register offset constants;
  - STATUS bit position constants;
  - the launch_state_t enum (IDLE, CONFIG, RUN, COMPLETE).
- Sub-module launch_fifo: synchronous FIFO of launch_desc_t, parameter DEPTH, with push/pop/full/empty/count ports and first-word-fall-through read.

Test Plan:
- After reset, read STATUS → 0; gpu_reset=1; execution_start=0; irq=0.
- Program {0x0,0x100,4,2}, write CONTROL=1 at cycle t → execution_start rises at t+4 with num_blocks=4, warps_per_block=2. Assert execution_done 10 cycles later → LAST_CYCLES=10, STATUS DONE=1, count[31:16]=1, irq=1. Write STATUS=0x1 → irq=0.
- Enqueue 5 launches with QUEUE_DEPTH=4 while the GPU is held busy (done never asserted) → first pops, 4 stay queued, none rejected. Issue a 6th → ERR_OVF=1 and queue count stays 4.
- NUM_BLOCKS=0 then CONTROL=1 → ERR_ZERO=1, queue count 0, BUSY stays 0.
- TIMEOUT_CYCLES=20, done never asserted → at the 20th RUN cycle ERR_TIMEOUT=1, gpu_reset=1, DONE=0. The next queued kernel then launches.
- Two queued kernels with different configs → gpu_reset is high for ≥2 cycles between them, and the config outputs change only while gpu_reset=1. Assert reset mid-RUN → gpu_reset=1 and queue count=0 the next cycle.
